// File: rtl/load_scoreboard_if.sv
// Issue / memory-response bundle between the issue stage and the load scoreboard.
interface load_scoreboard_if #(
  parameter int DEPTH = 4,
  parameter int REG_W = 5
);
  logic                         issue_valid;
  logic [REG_W-1:0]             issue_rs1;
  logic [REG_W-1:0]             issue_rs2;
  logic [REG_W-1:0]             issue_rd;
  logic                         issue_rf_wr;
  logic                         issue_load;
  logic                         flush;
  logic                         mem_rsp_valid;
  logic                         stall;
  logic                         issue_fire;
  logic [REG_W-1:0]             wb_rd;
  logic                         wb_rf_wr;
  logic [$clog2(DEPTH+1)-1:0]   outstanding;
  logic                         full;
  logic                         empty;
  logic                         rsp_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rf_wr, issue_load,
           flush, mem_rsp_valid,
    input  stall, issue_fire, wb_rd, wb_rf_wr, outstanding, full, empty, rsp_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rf_wr, issue_load,
           flush, mem_rsp_valid,
    output stall, issue_fire, wb_rd, wb_rf_wr, outstanding, full, empty, rsp_err
  );
endinterface

// File: rtl/load_scoreboard.sv
// Tracks destinations of outstanding loads, stalls dependent issues and
// publishes the in-order writeback destination as each response returns.
module load_scoreboard #(
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  load_scoreboard_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2 ** REG_W;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
  } entry_t;

  entry_t           fifo [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [NREG-1:0]  pending, pending_nxt;
  logic             rsp_err_q;

  entry_t head, push_ent;
  logic   empty, full, pop, push;
  logic   clr1, clr2, clrd, haz1, haz2, waw, stall, fire;

  assign head  = fifo[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = bus.mem_rsp_valid & ~empty;

  // A register whose load returns this cycle is released: forwarding covers it.
  assign clr1 = pop & head.wr & (head.rd == bus.issue_rs1);
  assign clr2 = pop & head.wr & (head.rd == bus.issue_rs2);
  assign clrd = pop & head.wr & (head.rd == bus.issue_rd);

  assign haz1 = (bus.issue_rs1 != '0) & pending[bus.issue_rs1] & ~clr1;
  assign haz2 = (bus.issue_rs2 != '0) & pending[bus.issue_rs2] & ~clr2;
  assign waw  = bus.issue_rf_wr & (bus.issue_rd != '0) & pending[bus.issue_rd] & ~clrd;

  // Full stalls regardless of a same-cycle pop.
  assign stall = bus.issue_valid & (haz1 | haz2 | waw | (bus.issue_load & full));
  assign fire  = bus.issue_valid & ~stall & ~bus.flush;
  assign push  = fire & bus.issue_load;

  assign push_ent.rd = bus.issue_rd;
  assign push_ent.wr = bus.issue_rf_wr & (bus.issue_rd != '0);

  // Set after clear so a same-register push/pop leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (pop & head.wr)      pending_nxt[head.rd]     = 1'b0;
    if (push & push_ent.wr) pending_nxt[push_ent.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pending   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      pending <= pending_nxt;
      if (bus.mem_rsp_valid & empty) rsp_err_q <= 1'b1;
    end
  end

  assign bus.stall       = stall;
  assign bus.issue_fire  = fire;
  assign bus.wb_rd       = empty ? '0 : head.rd;
  assign bus.wb_rf_wr    = pop & head.wr;
  assign bus.outstanding = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_load_scoreboard.sv
// Randomized plus directed checking of load_scoreboard against a queue-based model.
module tb_load_scoreboard;
  localparam int DEPTH = 4;
  localparam int REG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  load_scoreboard_if #(.DEPTH(DEPTH), .REG_W(REG_W)) bus ();

  load_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd;
    bit wr;
  } ent_t;

  ent_t mq[$];
  bit   m_err;
  int   checks = 0;
  int   errors = 0;

  logic o_stall, o_fire, o_wbwr, o_full, o_empty, o_err;
  int   o_wbrd, o_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit pend(input int r);
    foreach (mq[i]) if (mq[i].wr && mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Register blocks issue unless its load is the one returning right now.
  function automatic bit busy(input int r, input bit pop);
    bit rel;
    rel = 1'b0;
    if (pop) rel = mq[0].wr && (mq[0].rd == r);
    return (r != 0) && pend(r) && !rel;
  endfunction

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit wr, input bit ld, input bit fl, input bit rsp);
    bus.issue_valid   = v;
    bus.issue_rs1     = REG_W'(rs1);
    bus.issue_rs2     = REG_W'(rs2);
    bus.issue_rd      = REG_W'(rd);
    bus.issue_rf_wr   = wr;
    bus.issue_load    = ld;
    bus.flush         = fl;
    bus.mem_rsp_valid = rsp;
  endtask

  task automatic cycle(input bit v, input int rs1, input int rs2, input int rd,
                       input bit wr, input bit ld, input bit fl, input bit rsp);
    int n;
    bit pop, e_stall, e_fire, e_wbwr;
    int e_wbrd;
    @(negedge clk);
    drive(v, rs1, rs2, rd, wr, ld, fl, rsp);
    #1;
    n       = mq.size();
    pop     = rsp && (n > 0);
    e_stall = v && (busy(rs1, pop) || busy(rs2, pop) || (wr && busy(rd, pop)) ||
                    (ld && n == DEPTH));
    e_fire  = v && !e_stall && !fl;
    e_wbrd  = (n > 0) ? mq[0].rd : 0;
    e_wbwr  = pop ? mq[0].wr : 1'b0;
    o_stall = bus.stall;
    o_fire  = bus.issue_fire;
    o_wbrd  = int'(bus.wb_rd);
    o_wbwr  = bus.wb_rf_wr;
    o_out   = int'(bus.outstanding);
    o_full  = bus.full;
    o_empty = bus.empty;
    o_err   = bus.rsp_err;
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("issue_fire", 32'(o_fire), 32'(e_fire));
    chk("wb_rd", o_wbrd, e_wbrd);
    chk("wb_rf_wr", 32'(o_wbwr), 32'(e_wbwr));
    chk("outstanding", o_out, n);
    chk("full", 32'(o_full), 32'(n == DEPTH));
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("rsp_err", 32'(o_err), 32'(m_err));
    @(posedge clk);
    if (rsp && n == 0) m_err = 1'b1;
    if (pop) mq.delete(0);
    if (e_fire && ld) mq.push_back('{rd: rd, wr: wr && (rd != 0)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_err = 1'b0;
    chk("rst_outstanding", 32'(bus.outstanding), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 0);
    chk("rst_wb_rf_wr", 32'(bus.wb_rf_wr), 0);
  endtask

  initial begin
    int seq;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_err = 1'b0;

    // load rd=5, dependent add stalls until the response cycle
    do_reset();
    cycle(1, 0, 0, 5, 1, 1, 0, 0);
    cycle(1, 5, 0, 6, 1, 0, 0, 0);
    chk("t1_stall_a", 32'(o_stall), 1);
    cycle(1, 5, 0, 6, 1, 0, 0, 0);
    chk("t1_stall_b", 32'(o_stall), 1);
    cycle(1, 5, 0, 6, 1, 0, 0, 1);
    chk("t1_wb_rd", o_wbrd, 5);
    chk("t1_wb_rf_wr", 32'(o_wbwr), 1);
    chk("t1_stall_rel", 32'(o_stall), 0);
    chk("t1_fire", 32'(o_fire), 1);

    // fill to DEPTH, full stalls even with a pop, in-order drain
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, i, 1, 1, 0, 0);
    cycle(1, 0, 0, 9, 1, 1, 0, 1);
    chk("t2_full", 32'(o_full), 1);
    chk("t2_stall", 32'(o_stall), 1);
    chk("t2_wb_rd1", o_wbrd, 1);
    for (int i = 2; i <= 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      chk("t2_wb_rd", o_wbrd, i);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_empty", 32'(o_empty), 1);

    // load to x0 never marks pending but still takes a slot
    do_reset();
    cycle(1, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 3, 1, 0, 0, 0);
    chk("t3_stall", 32'(o_stall), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_wb_rf_wr", 32'(o_wbwr), 0);
    chk("t3_out1", o_out, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_out0", o_out, 0);

    // flushed load is not recorded; older load still retires
    do_reset();
    cycle(1, 0, 0, 3, 1, 1, 0, 0);
    cycle(1, 0, 0, 7, 1, 1, 1, 0);
    chk("t4_fire", 32'(o_fire), 0);
    cycle(1, 7, 0, 8, 1, 0, 0, 0);
    chk("t4_stall", 32'(o_stall), 0);
    chk("t4_fire2", 32'(o_fire), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_wb_rd", o_wbrd, 3);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_out", o_out, 0);

    // stray response sets sticky error
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err", 32'(o_err), 1);
    chk("t5_out", o_out, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_sticky", 32'(o_err), 1);
    do_reset();

    // fill/drain with simultaneous push+pop so pointers wrap several times
    seq = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        cycle(1, 0, 0, 1 + (seq % 31), 1, 1, 0, 0);
        seq++;
      end
      for (int i = 0; i < 6; i++) begin
        cycle(1, 0, 0, 1 + (seq % 31), 1, 1, 0, 1);
        seq++;
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_empty", 32'(o_empty), 1);
    end
    for (int r = 1; r < 32; r++) begin
      cycle(1, r, 0, 0, 0, 0, 0, 0);
      chk("t6_pending_clear", 32'(o_stall), 0);
    end

    // random traffic against the model, small register range for hazards
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) do_reset();
      else cycle($urandom_range(3) != 0, int'($urandom_range(7)), int'($urandom_range(7)),
                 int'($urandom_range(7)), $urandom_range(3) != 0, $urandom_range(1) == 1,
                 $urandom_range(7) == 0, $urandom_range(2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
